// File: rtl/winograd_output_transform_unit.sv
// Winograd F(4x4,3x3) output transform: Y' = A^T * M * A.
// M arrives one row per beat. Each row is reduced to four partial sums
// (the row pass), which are weighted by the column coefficients of that row
// and accumulated into a 4x4 tile. The finished tile is presented on a
// valid/ready output. The result is unscaled; the descaler removes the gain.
//
// state   | meaning
// S_ACCUM | accepting rows 0..5 of M, accumulating into acc_q
// S_OUT   | complete tile on tile_out, waiting for tile_ready
module winograd_output_transform_unit #(
  parameter  int IN_W  = 32,
  // Worst-case gain is 19*19 = 361 < 2^9, so ten extra bits always suffice.
  localparam int OUT_W = IN_W + 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic signed [IN_W-1:0]  row_in     [0:5],
  input  logic                    row_valid,
  output logic                    row_ready,
  output logic signed [OUT_W-1:0] tile_out   [0:3][0:3],
  output logic                    tile_valid,
  input  logic                    tile_ready
);

  typedef enum logic {S_ACCUM, S_OUT} state_t;

  state_t                  state_q;
  logic [2:0]              row_cnt_q;
  logic                    row_ready_q;
  logic                    tile_valid_q;
  logic signed [OUT_W-1:0] acc_q [0:3][0:3];
  logic signed [OUT_W-1:0] acc_d [0:3][0:3];
  logic signed [OUT_W-1:0] m     [0:5];
  logic signed [OUT_W-1:0] p     [0:3];
  logic                    accept;

  // a_i(r) * v using shifts and negation only.
  function automatic logic signed [OUT_W-1:0] col_term(
    input logic [2:0]              r,
    input logic [1:0]              i,
    input logic signed [OUT_W-1:0] v
  );
    logic signed [OUT_W-1:0] res;
    case (r)
      3'd0:    res = (i == 2'd0) ? v : '0;
      3'd1:    res = v;
      3'd2:    res = i[0] ? -v : v;
      3'd3:    res = v <<< i;
      3'd4:    res = i[0] ? -(v <<< i) : (v <<< i);
      3'd5:    res = (i == 2'd3) ? v : '0;
      default: res = '0;
    endcase
    return res;
  endfunction

  assign accept = row_valid && row_ready_q && !clear && (state_q == S_ACCUM);

  // Row pass: sign-extend the incoming row and form the four partial sums.
  always_comb begin
    for (int c = 0; c < 6; c++) begin
      m[c] = {{(OUT_W-IN_W){row_in[c][IN_W-1]}}, row_in[c]};
    end
    p[0] = m[0] + m[1] + m[2] + m[3] + m[4];
    p[1] = m[1] - m[2] + (m[3] <<< 1) - (m[4] <<< 1);
    p[2] = m[1] + m[2] + (m[3] <<< 2) + (m[4] <<< 2);
    p[3] = m[1] - m[2] + (m[3] <<< 3) - (m[4] <<< 3) + m[5];
  end

  // Column pass: row 0 overwrites the tile, later rows add into it.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc_d[i][j] = acc_q[i][j];
        if (accept) begin
          if (row_cnt_q == 3'd0)
            acc_d[i][j] = col_term(row_cnt_q, 2'(i), p[j]);
          else
            acc_d[i][j] = acc_q[i][j] + col_term(row_cnt_q, 2'(i), p[j]);
        end
      end
    end
  end

  // Accumulator tile register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          acc_q[i][j] <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_ACCUM;
      row_cnt_q    <= 3'd0;
      row_ready_q  <= 1'b0;
      tile_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_ACCUM: begin
          row_ready_q  <= 1'b1;
          tile_valid_q <= 1'b0;
          if (clear) begin
            row_cnt_q <= 3'd0;
          end else if (accept) begin
            if (row_cnt_q == 3'd5) begin
              row_cnt_q    <= 3'd0;
              state_q      <= S_OUT;
              row_ready_q  <= 1'b0;
              tile_valid_q <= 1'b1;
            end else begin
              row_cnt_q <= row_cnt_q + 3'd1;
            end
          end
        end
        S_OUT: begin
          // clear is deliberately ignored here; the tile handshake wins.
          if (tile_ready) begin
            state_q      <= S_ACCUM;
            tile_valid_q <= 1'b0;
            row_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_ACCUM;
          row_cnt_q    <= 3'd0;
          row_ready_q  <= 1'b0;
          tile_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign row_ready  = row_ready_q;
  assign tile_valid = tile_valid_q;
  assign tile_out   = acc_q;

endmodule

// File: tb/tb_winograd_output_transform_unit.sv
// Bench for winograd_output_transform_unit: matrix-level reference model
// Y = A^T * M * A, directed and random tiles, backpressure, clear and reset.
module tb_winograd_output_transform_unit;
  localparam int IN_W  = 32;
  localparam int OUT_W = 42;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    clear;
  logic signed [IN_W-1:0]  row_in   [0:5];
  logic                    row_valid;
  logic                    row_ready;
  logic signed [OUT_W-1:0] tile_out [0:3][0:3];
  logic                    tile_valid;
  logic                    tile_ready;

  winograd_output_transform_unit #(.IN_W(IN_W)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .row_in(row_in), .row_valid(row_valid), .row_ready(row_ready),
    .tile_out(tile_out), .tile_valid(tile_valid), .tile_ready(tile_ready)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  longint M [6][6];
  longint Y [4][4];
  int AT [4][6] = '{'{1, 1,  1, 1,  1, 0},
                    '{0, 1, -1, 2, -2, 0},
                    '{0, 1,  1, 4,  4, 0},
                    '{0, 1, -1, 8, -8, 1}};
  logic signed [OUT_W-1:0] cap [0:3][0:3];

  // Reference: plain matrix product A^T * M * A.
  function automatic void model();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        Y[i][j] = 0;
        for (int r = 0; r < 6; r++)
          for (int c = 0; c < 6; c++)
            Y[i][j] += longint'(AT[i][r]) * M[r][c] * longint'(AT[j][c]);
      end
  endfunction

  function automatic void fill_const(input longint v);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        M[r][c] = v;
  endfunction

  function automatic void fill_random();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        M[r][c] = longint'($signed($urandom()));
  endfunction

  // Drive rows 0..nrows-1 of M, one accepted row per beat.
  task automatic send_rows(input int nrows);
    for (int r = 0; r < nrows; r++) begin
      int b = 0;
      for (int c = 0; c < 6; c++) row_in[c] = IN_W'(M[r][c]);
      row_valid = 1'b1;
      while (!row_ready && b < 50) begin
        @(posedge clk); #1; b++;
      end
      if (!row_ready) begin
        n_total++;
        $display("FAIL row_ready_timeout row=%0d got=%0b want=1", r, row_ready);
      end
      @(posedge clk); #1;
    end
    row_valid = 1'b0;
  endtask

  // Wait for a tile, capture it, then complete the handshake.
  task automatic get_tile();
    int b = 0;
    while (!tile_valid && b < 50) begin
      @(posedge clk); #1; b++;
    end
    if (!tile_valid) begin
      n_total++;
      $display("FAIL tile_valid_timeout got=%0b want=1", tile_valid);
    end
    cap = tile_out;
    tile_ready = 1'b1;
    @(posedge clk); #1;
    tile_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic nz;
    @(posedge clk); #1;
    nz = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (tile_out[i][j] !== '0) nz = 1'b1;
    n_total++;
    if (nz !== 1'b0) $display("FAIL reset_tile_out got_nonzero=%0b want=0", nz);
    else n_pass++;
    n_total++;
    if (row_ready !== 1'b0) $display("FAIL reset_row_ready got=%0b want=0", row_ready);
    else n_pass++;
    n_total++;
    if (tile_valid !== 1'b0) $display("FAIL reset_tile_valid got=%0b want=0", tile_valid);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (row_ready !== 1'b1) $display("FAIL reset_release_row_ready got=%0b want=1", row_ready);
    else n_pass++;
  endtask

  task automatic test_impulses();
    // M[0][0] = 1 and M[5][5] = 1
    for (int k = 0; k < 2; k++) begin
      fill_const(0);
      M[5*k][5*k] = 1;
      model();
      send_rows(6);
      get_tile();
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          n_total++;
          if (cap[i][j] !== OUT_W'(Y[i][j]))
            $display("FAIL impulse%0d Y[%0d][%0d] got=%0d want=%0d", k, i, j, cap[i][j], Y[i][j]);
          else n_pass++;
        end
    end
    // M[3][3] = 1: Y[i][j] = a_i(3)*a_j(3), spot-checked against constants
    fill_const(0);
    M[3][3] = 1;
    send_rows(6);
    get_tile();
    n_total++;
    if (cap[0][0] !== 42'sd1) $display("FAIL imp33 Y00 got=%0d want=1", cap[0][0]); else n_pass++;
    n_total++;
    if (cap[1][2] !== 42'sd8) $display("FAIL imp33 Y12 got=%0d want=8", cap[1][2]); else n_pass++;
    n_total++;
    if (cap[2][3] !== 42'sd32) $display("FAIL imp33 Y23 got=%0d want=32", cap[2][3]); else n_pass++;
    n_total++;
    if (cap[3][3] !== 42'sd64) $display("FAIL imp33 Y33 got=%0d want=64", cap[3][3]); else n_pass++;
  endtask

  task automatic test_uniform();
    for (int k = 0; k < 2; k++) begin
      fill_const(k == 0 ? 1 : -1);
      model();
      send_rows(6);
      n_total++;
      if (tile_valid !== 1'b1) $display("FAIL uniform_latency tile_valid got=%0b want=1", tile_valid);
      else n_pass++;
      n_total++;
      if (row_ready !== 1'b0) $display("FAIL uniform_out_row_ready got=%0b want=0", row_ready);
      else n_pass++;
      get_tile();
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          n_total++;
          if (cap[i][j] !== OUT_W'(Y[i][j]))
            $display("FAIL uniform%0d Y[%0d][%0d] got=%0d want=%0d", k, i, j, cap[i][j], Y[i][j]);
          else n_pass++;
        end
      n_total++;
      if (cap[2][2] !== (k == 0 ? 42'sd100 : -42'sd100))
        $display("FAIL uniform%0d Y22_const got=%0d want=%0d", k, cap[2][2], k == 0 ? 100 : -100);
      else n_pass++;
    end
  endtask

  task automatic test_worst_case();
    longint kmax = 64'd2147483647;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        M[r][c] = (AT[3][r] * AT[3][c] < 0) ? -kmax : kmax;
    model();
    send_rows(6);
    get_tile();
    n_total++;
    if (cap[3][3] !== OUT_W'(361 * kmax))
      $display("FAIL worst_Y33 got=%0d want=%0d", cap[3][3], 361 * kmax);
    else n_pass++;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        n_total++;
        if (cap[i][j] !== OUT_W'(Y[i][j]))
          $display("FAIL worst Y[%0d][%0d] got=%0d want=%0d", i, j, cap[i][j], Y[i][j]);
        else n_pass++;
      end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      fill_random();
      model();
      send_rows(6);
      get_tile();
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          n_total++;
          if (cap[i][j] !== OUT_W'(Y[i][j]))
            $display("FAIL random%0d Y[%0d][%0d] got=%0d want=%0d", t, i, j, cap[i][j], Y[i][j]);
          else n_pass++;
        end
    end
  endtask

  task automatic test_backpressure();
    longint Yb [4][4];
    logic   diff;
    fill_random();
    model();
    Yb = Y;
    send_rows(6);
    fill_random();
    model();
    for (int c = 0; c < 6; c++) row_in[c] = IN_W'(M[0][c]);
    row_valid  = 1'b1;
    tile_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      clear = (cyc == 2);
      @(posedge clk); #1;
      diff = 1'b0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if (tile_out[i][j] !== OUT_W'(Yb[i][j])) diff = 1'b1;
      n_total++;
      if (diff !== 1'b0) $display("FAIL bp_tile_stable cyc=%0d got_diff=%0b want=0", cyc, diff);
      else n_pass++;
      n_total++;
      if (row_ready !== 1'b0) $display("FAIL bp_row_ready cyc=%0d got=%0b want=0", cyc, row_ready);
      else n_pass++;
      n_total++;
      if (tile_valid !== 1'b1) $display("FAIL bp_tile_valid cyc=%0d got=%0b want=1", cyc, tile_valid);
      else n_pass++;
    end
    clear = 1'b0;
    tile_ready = 1'b1;
    @(posedge clk); #1;
    tile_ready = 1'b0;
    n_total++;
    if (tile_valid !== 1'b0) $display("FAIL bp_handoff_tile_valid got=%0b want=0", tile_valid);
    else n_pass++;
    n_total++;
    if (row_ready !== 1'b1) $display("FAIL bp_handoff_row_ready got=%0b want=1", row_ready);
    else n_pass++;
    send_rows(6);
    get_tile();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        n_total++;
        if (cap[i][j] !== OUT_W'(Y[i][j]))
          $display("FAIL bp_next Y[%0d][%0d] got=%0d want=%0d", i, j, cap[i][j], Y[i][j]);
        else n_pass++;
      end
  endtask

  task automatic test_clear();
    for (int k = 0; k < 2; k++) begin
      fill_random();
      send_rows(3);
      // clear alone, then clear with a row presented that must be dropped
      for (int c = 0; c < 6; c++) row_in[c] = IN_W'(M[3][c]);
      row_valid = (k == 1);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      row_valid = 1'b0;
      fill_const(1);
      model();
      send_rows(6);
      get_tile();
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          n_total++;
          if (cap[i][j] !== OUT_W'(Y[i][j]))
            $display("FAIL clear%0d Y[%0d][%0d] got=%0d want=%0d", k, i, j, cap[i][j], Y[i][j]);
          else n_pass++;
        end
    end
  endtask

  task automatic test_rst_mid();
    logic nz;
    fill_random();
    send_rows(3);
    rst = 1'b1;
    #1;
    nz = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (tile_out[i][j] !== '0) nz = 1'b1;
    n_total++;
    if (nz !== 1'b0) $display("FAIL rstmid_tile_out got_nonzero=%0b want=0", nz);
    else n_pass++;
    n_total++;
    if (row_ready !== 1'b0 || tile_valid !== 1'b0)
      $display("FAIL rstmid_flags got=%0b%0b want=00", row_ready, tile_valid);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (row_ready !== 1'b1) $display("FAIL rstmid_release_row_ready got=%0b want=1", row_ready);
    else n_pass++;
    fill_const(1);
    model();
    send_rows(6);
    get_tile();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        n_total++;
        if (cap[i][j] !== OUT_W'(Y[i][j]))
          $display("FAIL rstmid Y[%0d][%0d] got=%0d want=%0d", i, j, cap[i][j], Y[i][j]);
        else n_pass++;
      end
  endtask

  initial begin
    rst        = 1'b1;
    clear      = 1'b0;
    row_valid  = 1'b0;
    tile_ready = 1'b0;
    for (int c = 0; c < 6; c++) row_in[c] = '0;
    test_reset();
    test_impulses();
    test_uniform();
    test_worst_case();
    test_random();
    test_backpressure();
    test_clear();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
